// File: rtl/uk101_pkg.sv
// Shared types and constants for the UK101 tape save capture path.
package uk101_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StCapture,
    StReady,
    StUpload
  } tsc_state_t;

  localparam logic [7:0] TSC_PAD_DEFAULT = 8'h1A;

endpackage

// File: rtl/tape_save_capture_ram.sv
// Simple dual-port synchronous byte RAM with registered read (maps onto M10K).
module capture_ram #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tape_save_capture.sv
// Captures ACIA transmit bytes during SAVE into a buffer and serves it to the
// HPS through the ioctl upload interface.
module tape_save_capture
  import uk101_pkg::*;
#(
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned TIMEOUT_CYCLES = 48000000,
  parameter logic [7:0]  PAD_BYTE       = TSC_PAD_DEFAULT
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            capture_en,
  input  logic [7:0]      tx_data,
  input  logic            tx_valid,
  input  logic            ioctl_upload,
  input  logic            ioctl_rd,
  input  logic [15:0]     ioctl_addr,
  output logic [7:0]      ioctl_din,
  output logic            upload_req,
  output logic            capturing,
  output logic            overflow,
  output logic [ADDR_W:0] length
);

  localparam int unsigned LW    = ADDR_W + 1;
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [TW-1:0] TIMER_MAX = '1;

  tsc_state_t      state_q, state_d;
  logic [LW-1:0]   length_q, length_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            overflow_q, overflow_d;
  logic            cap_en_q, upload_q;
  logic            cap_rise, up_rise, up_fall;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr, raddr_q;
  logic [7:0]        rdata;
  logic              rd_take, in_range;
  logic              zero_q, pad_q;

  assign cap_rise = capture_en & ~cap_en_q;
  assign up_rise  = ioctl_upload & ~upload_q;
  assign up_fall  = ~ioctl_upload & upload_q;

  always_comb begin
    state_d    = state_q;
    length_d   = length_q;
    timer_d    = timer_q;
    overflow_d = overflow_q;
    we         = 1'b0;
    waddr      = length_q[ADDR_W-1:0];
    unique case (state_q)
      StIdle: begin
        if (cap_rise) begin
          state_d    = StArmed;
          length_d   = '0;
          overflow_d = 1'b0;
        end
      end
      StArmed: begin
        if (tx_valid) begin
          we       = 1'b1;
          waddr    = '0;
          length_d = LW'(1);
          timer_d  = '0;
          state_d  = StCapture;
        end else if (!capture_en) begin
          state_d  = StIdle;
          length_d = '0;
        end
      end
      StCapture: begin
        if (tx_valid) begin
          // A byte always restarts the idle timer, even when it is dropped.
          timer_d = '0;
          if (length_q < DEPTH_L) begin
            we       = 1'b1;
            length_d = length_q + LW'(1);
          end else begin
            overflow_d = 1'b1;
          end
          if (!capture_en) begin
            state_d = StReady;
          end
        end else if (!capture_en) begin
          state_d = StReady;
        end else begin
          if (timer_q != TIMER_MAX) begin
            timer_d = timer_q + TW'(1);
          end
          if (32'(timer_d) >= TIMEOUT_CYCLES) begin
            state_d = StReady;
          end
        end
      end
      StReady: begin
        if (up_rise) begin
          state_d = StUpload;
        end else if (cap_rise) begin
          state_d    = StArmed;
          length_d   = '0;
          overflow_d = 1'b0;
        end
      end
      StUpload: begin
        if (up_fall) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    cap_en_q <= capture_en;
    upload_q <= ioctl_upload;
    if (reset) begin
      state_q    <= StIdle;
      length_q   <= '0;
      timer_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      length_q   <= length_d;
      timer_q    <= timer_d;
      overflow_q <= overflow_d;
    end
  end

  // Read address is held between strobes so the RAM output register keeps
  // presenting the last read byte.
  assign rd_take  = (state_q == StUpload) && ioctl_rd;
  assign in_range = {16'h0000, ioctl_addr} < 32'(length_q);
  assign raddr    = rd_take ? ioctl_addr[ADDR_W-1:0] : raddr_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      zero_q  <= 1'b1;
      pad_q   <= 1'b0;
      raddr_q <= '0;
    end else if (rd_take) begin
      zero_q  <= 1'b0;
      pad_q   <= ~in_range;
      raddr_q <= ioctl_addr[ADDR_W-1:0];
    end
  end

  capture_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clk_sys),
    .we    (we),
    .waddr (waddr),
    .wdata (tx_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign ioctl_din  = zero_q ? 8'h00 : (pad_q ? PAD_BYTE : rdata);
  assign upload_req = (state_q == StReady) || (state_q == StUpload);
  assign capturing  = (state_q == StArmed) || (state_q == StCapture);
  assign overflow   = overflow_q;
  assign length     = length_q;

endmodule

// File: tb/tb_tape_save_capture.sv
// Directed bench for tape_save_capture; upload reads are checked by a
// scoreboard monitor that pops expected bytes one cycle after each strobe.
module tb_tape_save_capture;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned TIMEOUT = 100;

  logic            clk_sys = 1'b0;
  logic            reset;
  logic            capture_en;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            ioctl_upload;
  logic            ioctl_rd;
  logic [15:0]     ioctl_addr;
  logic [7:0]      ioctl_din;
  logic            upload_req;
  logic            capturing;
  logic            overflow;
  logic [ADDR_W:0] length;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] exp_q [$];
  logic       rd_seen = 1'b0;

  always #5 clk_sys = ~clk_sys;

  tape_save_capture #(
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TIMEOUT),
    .PAD_BYTE       (8'h1A)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .capture_en   (capture_en),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .upload_req   (upload_req),
    .capturing    (capturing),
    .overflow     (overflow),
    .length       (length)
  );

  always @(posedge clk_sys) rd_seen <= ioctl_rd & ~reset;

  // Monitor: one cycle after a read strobe, ioctl_din must match the queue head.
  always @(negedge clk_sys) begin
    if (rd_seen) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data: got %02h with no expected byte queued", ioctl_din);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (ioctl_din !== e) begin
          errors++;
          $display("FAIL rd_data: got %02h expected %02h", ioctl_din, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic arm();
    capture_en = 1'b0;
    step(1);
    capture_en = 1'b1;
    step(1);
  endtask

  task automatic strobe(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    step(1);
    tx_valid = 1'b0;
  endtask

  task automatic close_capture();
    capture_en = 1'b0;
    step(1);
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e);
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    exp_q.push_back(e);
    step(1);
    ioctl_rd = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; capture_en = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = 16'h0000;
    step(3);
    reset = 1'b0;
    step(1);
    chk("reset_upload_req", 32'(upload_req), 0);
    chk("reset_capturing",  32'(capturing), 0);
    chk("reset_length",     32'(length), 0);
    chk("reset_overflow",   32'(overflow), 0);
    chk("reset_din",        32'(ioctl_din), 0);

    // Test 1: basic capture and upload with padding.
    arm();
    chk("t1_armed", 32'(capturing), 1);
    strobe(8'h41); strobe(8'h42); strobe(8'h43);
    close_capture();
    step(1);
    chk("t1_upload_req", 32'(upload_req), 1);
    chk("t1_length",     32'(length), 3);
    chk("t1_capturing",  32'(capturing), 0);
    ioctl_upload = 1'b1;
    step(1);
    rd(16'd0, 8'h41); rd(16'd1, 8'h42); rd(16'd2, 8'h43);
    rd(16'd3, 8'h1A); rd(16'd4, 8'h1A);
    step(3);
    chk("t1_din_hold", 32'(ioctl_din), 32'h1A);
    ioctl_upload = 1'b0;
    step(2);
    chk("t1_idle_req",    32'(upload_req), 0);
    chk("t1_length_kept", 32'(length), 3);

    // ARMED abort with no bytes.
    arm();
    close_capture();
    step(1);
    chk("abort_capturing", 32'(capturing), 0);
    chk("abort_req",       32'(upload_req), 0);
    chk("abort_length",    32'(length), 0);

    // Test 2: idle timeout and restart.
    arm();
    strobe(8'h77);
    step(99);
    chk("t2_cap_at_100", 32'(capturing), 1);
    chk("t2_req_at_100", 32'(upload_req), 0);
    step(1);
    chk("t2_req_at_101", 32'(upload_req), 1);
    arm();
    strobe(8'h01);
    step(49);
    strobe(8'h02);
    step(99);
    chk("t2b_req_at_150", 32'(upload_req), 0);
    chk("t2b_cap_at_150", 32'(capturing), 1);
    step(1);
    chk("t2b_req_at_151", 32'(upload_req), 1);
    chk("t2b_length",     32'(length), 2);

    // Test 3: overflow in a 16-byte buffer, then test 5: reset mid-upload.
    arm();
    for (int i = 0; i < 20; i++) strobe(8'(i));
    close_capture();
    step(1);
    chk("t3_length",   32'(length), 16);
    chk("t3_overflow", 32'(overflow), 1);
    ioctl_upload = 1'b1;
    step(1);
    rd(16'd15, 8'h0F);
    rd(16'd16, 8'h1A);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t5_req",       32'(upload_req), 0);
    chk("t5_length",    32'(length), 0);
    chk("t5_overflow",  32'(overflow), 0);
    chk("t5_din",       32'(ioctl_din), 0);
    chk("t5_capturing", 32'(capturing), 0);
    ioctl_upload = 1'b0;
    step(1);

    // Test 4: byte coincident with capture_en falling.
    arm();
    strobe(8'h10); strobe(8'h11);
    tx_valid = 1'b1; tx_data = 8'h55; capture_en = 1'b0;
    step(1);
    tx_valid = 1'b0;
    chk("t4_length", 32'(length), 3);
    chk("t4_req",    32'(upload_req), 1);
    ioctl_upload = 1'b1;
    step(1);
    rd(16'd2, 8'h55);
    rd(16'hFFFF, 8'h1A);
    rd(16'h8001, 8'h1A);
    rd(16'd0, 8'h10);
    ioctl_upload = 1'b0;
    step(1);

    // Test 6: strobes in READY and IDLE are ignored.
    arm();
    strobe(8'hAA); strobe(8'hBB);
    close_capture();
    step(1);
    strobe(8'hCC);
    chk("t6_ready_length", 32'(length), 2);
    chk("t6_ready_req",    32'(upload_req), 1);
    ioctl_upload = 1'b1;
    step(1);
    rd(16'd0, 8'hAA); rd(16'd1, 8'hBB); rd(16'd2, 8'h1A);
    ioctl_upload = 1'b0;
    step(2);
    strobe(8'hDD);
    step(1);
    chk("t6_idle_length", 32'(length), 2);
    chk("t6_idle_cap",    32'(capturing), 0);
    chk("t6_idle_req",    32'(upload_req), 0);

    step(2);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rd_queue: %0d expected bytes never presented, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/tape_save_capture.md
Name: tape_save_capture

Overview:
- Captures the byte stream the UK101/OSI 6850 ACIA transmits during a BASIC SAVE or monitor dump into an on-chip buffer.
- Serves that buffer to the HPS through the ioctl upload interface, so the user saves a TXT/BAS/LOD file to SD.
- This is the reverse of the existing "Load Ascii" ioctl download path.
- Sits beside the uk101 instance in emu. It is fed from the ACIA transmit-byte strobe and connects to hps_io upload signals.

Parameters:
- ADDR_W, 14, buffer address width; buffer depth is DEPTH = 2**ADDR_W bytes.
- TIMEOUT_CYCLES, 48000000, idle cycles after the last byte before the capture closes automatically (1 s at 48 MHz).
- PAD_BYTE, 8'h1A, value returned for upload reads at or beyond the captured length.

Ports:
- clk_sys  in  1  system clock (48 MHz); the only clock.
- reset  in  1  synchronous, active-high reset.
- capture_en  in  1  OSD "Save to file" enable, level.
- tx_data  in  8  byte being transmitted by the ACIA.
- tx_valid  in  1  one-cycle strobe; tx_data is valid in that cycle.
- ioctl_upload  in  1  HPS upload in progress, level.
- ioctl_rd  in  1  HPS read strobe, one cycle.
- ioctl_addr  in  16  HPS byte address.
- ioctl_din  out  8  read data to HPS.
- upload_req  out  1  buffer closed, data ready for upload.
- capturing  out  1  high in ARMED or CAPTURE.
- overflow  out  1  sticky; at least one byte was dropped because the buffer was full.
- length  out  ADDR_W+1  number of bytes captured.

Behaviour:
- Reset (any state, including mid-capture or mid-upload) takes effect next cycle:
  - state=IDLE; length=0; overflow=0; upload_req=0; ioctl_din=0; timer=0.
  - RAM contents are not cleared.
- States: IDLE, ARMED, CAPTURE, READY, UPLOAD.
- IDLE:
  - A rising edge of capture_en (registered previous value) goes to ARMED.
  - Entering ARMED clears length and overflow.
  - tx_valid is ignored.
- ARMED:
  - tx_valid writes tx_data at address 0, sets length=1, clears timer, goes to CAPTURE.
  - capture_en low (with no tx_valid) returns to IDLE with length=0.
- CAPTURE:
  - tx_valid with length<DEPTH writes mem[length], then length++ and timer=0.
  - tx_valid with length==DEPTH drops the byte and sets overflow=1; timer still resets.
  - With no tx_valid, timer++ (saturating). When timer reaches TIMEOUT_CYCLES, go to READY.
  - Latency example: strobe in cycle 0, no strobes in cycles 1..T where T=TIMEOUT_CYCLES; READY and upload_req=1 are visible in cycle T+1.
  - capture_en low goes to READY next cycle.
  - tx_valid in the same cycle as capture_en low or a timeout: the byte is accepted first, then:
    - capture_en low: go to READY.
    - timeout coincident with a byte: the timer reset wins and the state stays CAPTURE.
- READY:
  - upload_req=1; tx_valid ignored.
  - Rising edge of ioctl_upload goes to UPLOAD.
  - Rising edge of capture_en re-arms (ARMED); the buffer is discarded and upload_req=0.
- UPLOAD:
  - upload_req stays 1.
  - On ioctl_rd, ioctl_din is registered with a latency of exactly 1 cycle:
    - mem[ioctl_addr[ADDR_W-1:0]] if ioctl_addr < length;
    - otherwise PAD_BYTE, including any ioctl_addr >= DEPTH.
  - ioctl_din holds its value between reads.
  - Falling edge of ioctl_upload goes to IDLE with upload_req=0. length keeps its value until the next arm.
- capturing = (state==ARMED || state==CAPTURE).
- Arithmetic and widths:
  - length and timer saturate and never wrap.
  - timer width is $clog2(TIMEOUT_CYCLES+1).
  - The ioctl_addr compare uses the full 16 bits, zero-extended against length.

Decomposition:
- Package uk101_pkg holds:
  - the state enum typedef tsc_state_t;
  - localparam TSC_PAD_DEFAULT = 8'h1A.
- Sub-module capture_ram:
  - simple dual-port synchronous RAM, DEPTH x 8;
  - write port: we, waddr, wdata;
  - read port: raddr, rdata, with 1-cycle read latency, so it infers M10K.
- The top FSM, counters and pad mux live in tape_save_capture.

Test Plan:
1. Arm, strobe 8'h41, 8'h42, 8'h43, drop capture_en -> READY, length=3, upload_req=1. Raise ioctl_upload and read addr 0..4 -> ioctl_din one cycle later = 41, 42, 43, 1A, 1A.
2. TIMEOUT_CYCLES=100: one strobe at cycle 0 -> state CAPTURE through cycle 100, READY and upload_req=1 at cycle 101. A second strobe at cycle 50 restarts the count, giving READY at cycle 151.
3. ADDR_W=4: strobe 20 bytes 0x00..0x13 -> length=16, overflow=1. Upload addr 15 -> 0x0F; addr 16 -> 0x1A.
4. tx_valid=1 (0x55) in the same cycle capture_en falls -> length increments to n+1, then READY, and mem[n]=0x55.
5. Assert reset during UPLOAD after two reads -> next cycle IDLE, upload_req=0, length=0, ioctl_din=0, overflow=0.
6. Strobes while in IDLE and in READY -> length unchanged; a subsequent upload returns the original data.
